// File: rtl/alu_op_sequencer.sv
// Control-unit slice that steps one ALU instruction through bus register transfers:
// load Y, execute into Z, write Z low (and high for MUL/DIV) back, then pulse done.
module alu_op_sequencer #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [3:0] opcode,
  output logic       ready,
  output logic       src_a_out,
  output logic       y_in,
  output logic       src_b_out,
  output logic [3:0] alu_op,
  output logic       alu_en,
  output logic       z_in,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       dest_lo_in,
  output logic       dest_hi_in,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WR_LO,
    S_WR_HI,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] OP_NEG      = 4'd2;
  localparam logic [3:0] OP_NOT      = 4'd3;
  localparam logic [3:0] OP_MUL      = 4'd6;
  localparam logic [3:0] OP_DIV      = 4'd7;
  localparam logic [3:0] OP_LAST_OK  = 4'd12;
  localparam logic [3:0] EXEC_LAST   = 4'(MULDIV_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] count;
  logic [3:0] op_q;
  logic       is_muldiv;
  logic       is_unary;
  logic       exec_final;

  assign is_muldiv  = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_unary   = (op_q == OP_NEG) || (op_q == OP_NOT);
  assign exec_final = !is_muldiv || (count == EXEC_LAST);

  // count sits at zero outside EXEC, so it starts from 0 on every EXEC entry
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= S_IDLE;
      count <= 4'd0;
      op_q  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start)
        op_q <= opcode;
      if (state == S_EXEC)
        count <= count + 4'd1;
      else
        count <= 4'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (opcode > OP_LAST_OK) ? S_ERR : S_LOAD_Y;
      end
      S_LOAD_Y: state_nxt = S_EXEC;
      S_EXEC:   if (exec_final) state_nxt = S_WR_LO;
      S_WR_LO:  state_nxt = is_muldiv ? S_WR_HI : S_DONE;
      S_WR_HI:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: everything decodes from the registered state and latched opcode
  always_comb begin
    ready      = 1'b0;
    src_a_out  = 1'b0;
    y_in       = 1'b0;
    src_b_out  = 1'b0;
    alu_op     = 4'd0;
    alu_en     = 1'b0;
    z_in       = 1'b0;
    zlo_out    = 1'b0;
    zhi_out    = 1'b0;
    dest_lo_in = 1'b0;
    dest_hi_in = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE:   ready = 1'b1;
      S_LOAD_Y: begin
        src_a_out = 1'b1;
        y_in      = 1'b1;
      end
      S_EXEC: begin
        alu_en    = 1'b1;
        alu_op    = op_q;
        src_b_out = !is_unary;
        z_in      = exec_final;
      end
      S_WR_LO: begin
        zlo_out    = 1'b1;
        dest_lo_in = 1'b1;
      end
      S_WR_HI: begin
        zhi_out    = 1'b1;
        dest_hi_in = 1'b1;
      end
      S_DONE:   done = 1'b1;
      S_ERR:    err  = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: two instances (MULDIV_CYCLES=4 and 1) share
// stimulus; each cycle's strobes and alu_op are compared against hand-written traces.
module tb_alu_op_sequencer;

  logic       clock;
  logic       clear;
  logic       start;
  logic [3:0] opcode;

  logic       ready_a, src_a_a, y_in_a, src_b_a, alu_en_a, z_in_a;
  logic       zlo_a, zhi_a, dlo_a, dhi_a, done_a, err_a;
  logic [3:0] alu_op_a;
  logic       ready_b, src_a_b, y_in_b, src_b_b, alu_en_b, z_in_b;
  logic       zlo_b, zhi_b, dlo_b, dhi_b, done_b, err_b;
  logic [3:0] alu_op_b;

  int n_vec = 0;
  int n_err = 0;

  // Strobe vector bit order: ready src_a y_in src_b alu_en z_in zlo zhi dlo dhi done err
  localparam logic [11:0] IDL  = 12'h800;
  localparam logic [11:0] LDY  = 12'h600;
  localparam logic [11:0] EXB  = 12'h180;
  localparam logic [11:0] EXBZ = 12'h1C0;
  localparam logic [11:0] EXUZ = 12'h0C0;
  localparam logic [11:0] WLO  = 12'h028;
  localparam logic [11:0] WHI  = 12'h014;
  localparam logic [11:0] DN   = 12'h002;
  localparam logic [11:0] ER   = 12'h001;

  alu_op_sequencer #(.MULDIV_CYCLES(4)) u_dut4 (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .ready(ready_a), .src_a_out(src_a_a), .y_in(y_in_a), .src_b_out(src_b_a),
    .alu_op(alu_op_a), .alu_en(alu_en_a), .z_in(z_in_a), .zlo_out(zlo_a),
    .zhi_out(zhi_a), .dest_lo_in(dlo_a), .dest_hi_in(dhi_a), .done(done_a), .err(err_a)
  );

  alu_op_sequencer #(.MULDIV_CYCLES(1)) u_dut1 (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .ready(ready_b), .src_a_out(src_a_b), .y_in(y_in_b), .src_b_out(src_b_b),
    .alu_op(alu_op_b), .alu_en(alu_en_b), .z_in(z_in_b), .zlo_out(zlo_b),
    .zhi_out(zhi_b), .dest_lo_in(dlo_b), .dest_hi_in(dhi_b), .done(done_b), .err(err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] obs(input bit sel);
    if (!sel)
      return {alu_op_a, ready_a, src_a_a, y_in_a, src_b_a, alu_en_a, z_in_a,
              zlo_a, zhi_a, dlo_a, dhi_a, done_a, err_a};
    return {alu_op_b, ready_b, src_a_b, y_in_b, src_b_b, alu_en_b, z_in_b,
            zlo_b, zhi_b, dlo_b, dhi_b, done_b, err_b};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got op=%h strb=%03h, expected op=%h strb=%03h",
               tag, got[15:12], got[11:0], exp[15:12], exp[11:0]);
    end
  endtask

  // advance one clock, then compare away from the edge
  task automatic step(input bit sel, input string tag, input logic [3:0] op, input logic [11:0] s);
    @(posedge clock);
    #1;
    check_eq(tag, obs(sel), {op, s});
  endtask

  // present a one-cycle start request; checks the first cycle after the accepting edge
  task automatic issue(input bit sel, input string tag, input logic [3:0] op_in,
                       input logic [3:0] op, input logic [11:0] s);
    start  = 1'b1;
    opcode = op_in;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_eq(tag, obs(sel), {op, s});
  endtask

  initial begin
    clear  = 1'b0;
    start  = 1'b0;
    opcode = 4'd0;
    @(posedge clock);
    step(0, "rst4", 4'd0, IDL);
    check_eq("rst1", obs(1), {4'd0, IDL});
    clear = 1'b1;
    step(0, "idle4", 4'd0, IDL);

    // ADD: done in the 4th cycle, no high-word strobes
    issue(0, "add_k1", 4'h4, 4'd0, LDY);
    step(0, "add_k2", 4'h4, EXBZ);
    step(0, "add_k3", 4'h0, WLO);
    step(0, "add_k4", 4'h0, DN);
    step(0, "add_k5", 4'h0, IDL);

    // MUL with 4 execute cycles: z_in only in the last, done at cycle 8
    issue(0, "mul_k1", 4'h6, 4'd0, LDY);
    step(0, "mul_k2", 4'h6, EXB);
    step(0, "mul_k3", 4'h6, EXB);
    step(0, "mul_k4", 4'h6, EXB);
    step(0, "mul_k5", 4'h6, EXBZ);
    step(0, "mul_k6", 4'h0, WLO);
    step(0, "mul_k7", 4'h0, WHI);
    step(0, "mul_k8", 4'h0, DN);
    step(0, "mul_k9", 4'h0, IDL);

    // DIV on the single-cycle instance: done at cycle 5; then finish the 4-cycle one
    issue(1, "div1_k1", 4'h7, 4'd0, LDY);
    step(1, "div1_k2", 4'h7, EXBZ);
    step(1, "div1_k3", 4'h0, WLO);
    step(1, "div1_k4", 4'h0, WHI);
    step(1, "div1_k5", 4'h0, DN);
    step(1, "div1_k6", 4'h0, IDL);
    step(0, "div4_k7", 4'h0, WHI);
    step(0, "div4_k8", 4'h0, DN);
    step(0, "div4_k9", 4'h0, IDL);

    // NOT: operand B is never driven
    issue(0, "not_k1", 4'h3, 4'd0, LDY);
    step(0, "not_k2", 4'h3, EXUZ);
    step(0, "not_k3", 4'h0, WLO);
    step(0, "not_k4", 4'h0, DN);
    step(0, "not_k5", 4'h0, IDL);

    // Illegal opcodes: err pulse then ready
    issue(0, "ill13_k1", 4'hD, 4'd0, ER);
    step(0, "ill13_k2", 4'h0, IDL);
    issue(0, "ill15_k1", 4'hF, 4'd0, ER);
    step(0, "ill15_k2", 4'h0, IDL);

    // start held high: a new op is accepted every 5 cycles
    start  = 1'b1;
    opcode = 4'h0;
    step(0, "busy_k1", 4'h0, LDY);
    step(0, "busy_k2", 4'h0, EXBZ);
    step(0, "busy_k3", 4'h0, WLO);
    step(0, "busy_k4", 4'h0, DN);
    step(0, "busy_k5", 4'h0, IDL);
    step(0, "busy_k6", 4'h0, LDY);
    step(0, "busy_k7", 4'h0, EXBZ);
    step(0, "busy_k8", 4'h0, WLO);
    step(0, "busy_k9", 4'h0, DN);
    start = 1'b0;
    step(0, "busy_k10", 4'h0, IDL);
    step(0, "busy_k11", 4'h0, IDL);

    // start during EXEC is ignored and the latched opcode holds
    issue(0, "drop_k1", 4'h4, 4'd0, LDY);
    step(0, "drop_k2", 4'h4, EXBZ);
    start  = 1'b1;
    opcode = 4'h1;
    #1;
    check_eq("drop_aluop", obs(0), {4'h4, EXBZ});
    step(0, "drop_k3", 4'h0, WLO);
    start = 1'b0;
    step(0, "drop_k4", 4'h0, DN);
    step(0, "drop_k5", 4'h0, IDL);
    step(0, "drop_k6", 4'h0, IDL);

    // reset in the 2nd EXEC cycle of MUL: everything drops, no done afterwards
    issue(0, "rmul_k1", 4'h6, 4'd0, LDY);
    step(0, "rmul_k2", 4'h6, EXB);
    step(0, "rmul_k3", 4'h6, EXB);
    clear = 1'b0;
    step(0, "rmul_rst", 4'h0, IDL);
    check_eq("rmul_rst1", obs(1), {4'd0, IDL});
    clear = 1'b1;
    for (int i = 0; i < 8; i++)
      step(0, $sformatf("rmul_quiet%0d", i), 4'h0, IDL);

    // reset coincident with start: the request is not taken
    clear  = 1'b0;
    start  = 1'b1;
    opcode = 4'h4;
    step(0, "rstart_k1", 4'h0, IDL);
    clear = 1'b1;
    start = 1'b0;
    step(0, "rstart_k2", 4'h0, IDL);
    check_eq("rstart_k2b", obs(1), {4'd0, IDL});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-unit slice that runs one ALU instruction as a series of bus register-transfer steps.
- Per step: operand A into Y, operand B onto the bus with the ALU enabled, capture the 64-bit result into Z, write Z low/high to destination registers.
- Sits between instruction decode (start/opcode) and the datapath strobe lines.
- MUL/DIV get a configurable multi-cycle execute window and a second write-back step for the high word.

Parameters:
- MULDIV_CYCLES, 4: number of EXEC cycles held for MUL (0110) and DIV (0111); legal range 1..15.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- clear  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- opcode  in  4  ALU op code; latched when start is accepted.
- ready  out  1  high in IDLE only.
- src_a_out  out  1  decode drives operand A onto the bus.
- y_in  out  1  load Y from the bus.
- src_b_out  out  1  decode drives operand B onto the bus.
- alu_op  out  4  operation select to ALU.
- alu_en  out  1  ALU enable.
- z_in  out  1  capture the 64-bit ALU result into Z.
- zlo_out  out  1  Z[31:0] onto the bus.
- zhi_out  out  1  Z[63:32] onto the bus.
- dest_lo_in  out  1  load the destination register from the bus.
- dest_hi_in  out  1  load the HI register from the bus.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Reset (clear=0 at an edge): state=IDLE, count=0, opcode register=0, alu_op=0. All strobes, done and err are 0; ready=1. Reset takes priority over every other event, including start.
- States: IDLE, LOAD_Y, EXEC, WR_LO, WR_HI, DONE, ERR. All outputs are decoded from the registered state only (Moore).
- IDLE: ready=1. On start=1, latch opcode.
  - opcode 0..12 -> LOAD_Y.
  - opcode 13..15 -> ERR.
- LOAD_Y (1 cycle): src_a_out=1, y_in=1 -> EXEC. Applies to unary ops NEGATE/NOT too, since they operate on Y.
- EXEC: alu_en=1 and alu_op=latched opcode for the whole state. src_b_out=1, except for NEGATE(0010)/NOT(0011), where it is 0.
  - Non-MUL/DIV: 1 cycle, z_in=1 -> WR_LO.
  - MUL/DIV: count loads 0 on entry and increments each cycle. Stay MULDIV_CYCLES cycles; z_in=1 only in the final cycle (count=MULDIV_CYCLES-1) -> WR_LO.
- WR_LO (1 cycle): zlo_out=1, dest_lo_in=1. MUL/DIV -> WR_HI; others -> DONE.
- WR_HI (1 cycle): zhi_out=1, dest_hi_in=1 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- ERR (1 cycle): err=1, no datapath strobe -> IDLE.
- Latency from the accepting edge to the done pulse:
  - single-cycle ops: 4 cycles.
  - MUL/DIV: MULDIV_CYCLES+4 cycles.
- Cycles between done and the next start: 1 (ready returns in the cycle after DONE).
- Mutual exclusion invariants:
  - at most one of {src_a_out, src_b_out, zlo_out, zhi_out} high per cycle.
  - z_in never high outside EXEC.
- start while ready=0 is ignored, not queued. opcode changes after acceptance have no effect.
- clear=0 mid-operation: strobes drop at the next edge; no done or err is issued; any partially written result is abandoned.

Test Plan:
- ADD: start with opcode=0100 in IDLE -> LOAD_Y(src_a_out,y_in), EXEC(src_b_out,alu_en,alu_op=0100,z_in), WR_LO, then done 4 cycles after the accept edge; zhi_out and dest_hi_in never asserted.
- MUL at MULDIV_CYCLES=4: opcode=0110 -> alu_en high for 4 cycles, z_in only on the 4th, WR_LO then WR_HI, done 8 cycles after accept. Repeat with DIV=0111 and MULDIV_CYCLES=1 -> done at 5.
- NOT: opcode=0011 -> src_b_out stays 0 throughout EXEC; done at 4 cycles.
- Illegal opcode 1101 -> err pulse 1 cycle after accept; no strobe asserted; ready high again next cycle. Repeat with opcode=1111.
- Busy behaviour: hold start=1 with opcode=0000 continuously -> a new operation is accepted exactly every 5 cycles. A start pulse with opcode=0001 during EXEC of an ADD is dropped and alu_op stays 0100.
- Reset: clear=0 during the 2nd EXEC cycle of MUL -> next cycle all strobes 0, ready=1, no done. clear=0 coincident with start=1 in IDLE -> request not accepted.
